// File: rtl/sram_burst_ctrl.sv
// Burst SRAM access controller: one read/write request of 1..2**LEN_W-1 words, each held WAIT_STATES cycles.
// Optional start-time address range check is enabled with `define SRAM_BURST_CTRL_BOUND_CHK_EN.
module sram_burst_ctrl #(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 32,
  parameter int WAIT_STATES = 3,
  parameter int LEN_W       = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              writemode,
  input  logic [ADDR_W-1:0] i_address,
  input  logic [LEN_W-1:0]  i_len,
  input  logic [DATA_W-1:0] i_w_data,
  output logic              w_next,
  output logic [DATA_W-1:0] i_r_data,
  output logic              r_valid,
  output logic              busy,
  output logic              io_done,
  output logic              err,
  output logic              read_enable,
  output logic              write_enable,
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] w_data,
  input  logic [DATA_W-1:0] r_data
);

  // state  | meaning
  // IDLE   | waiting for start, enables low
  // ACCESS | one word on the SRAM port for WAIT_STATES cycles
  // GAP    | one idle cycle between words, address advances
  // DONE   | request finished, io_done pulse
  // ERR    | request rejected by range check, err + io_done pulse
  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] ACCESS = 3'd1;
  localparam logic [2:0] GAP    = 3'd2;
  localparam logic [2:0] DONE   = 3'd3;
  localparam logic [2:0] ERR    = 3'd4;

  localparam int WC_W = (WAIT_STATES > 1) ? $clog2(WAIT_STATES) : 1;
  localparam logic [WC_W-1:0] WAIT_LOAD = WC_W'(WAIT_STATES - 1);

  logic [2:0]       state;
  logic             mode;
  logic [WC_W-1:0]  wait_cnt;
  logic [LEN_W-1:0] word_cnt;
  logic [LEN_W-1:0] len_m1;

  // word_cnt holds the number of words still to go after the current one
  assign len_m1 = (i_len == '0) ? '0 : i_len - 1'b1;
  assign busy   = (state != IDLE);

`ifdef SRAM_BURST_CTRL_BOUND_CHK_EN
  logic [ADDR_W:0] last_addr;
  logic            out_of_range;
  assign last_addr    = {1'b0, i_address} + (ADDR_W+1)'(len_m1);
  assign out_of_range = last_addr[ADDR_W];
`else
  assign err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      mode         <= 1'b0;
      wait_cnt     <= '0;
      word_cnt     <= '0;
      w_next       <= 1'b0;
      i_r_data     <= '0;
      r_valid      <= 1'b0;
      io_done      <= 1'b0;
      read_enable  <= 1'b0;
      write_enable <= 1'b0;
      address      <= '0;
      w_data       <= '0;
`ifdef SRAM_BURST_CTRL_BOUND_CHK_EN
      err          <= 1'b0;
`endif
    end else begin
      w_next  <= 1'b0;
      r_valid <= 1'b0;
      io_done <= 1'b0;
`ifdef SRAM_BURST_CTRL_BOUND_CHK_EN
      err     <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (start) begin
            mode     <= writemode;
            address  <= i_address;
            word_cnt <= len_m1;
            wait_cnt <= WAIT_LOAD;
`ifdef SRAM_BURST_CTRL_BOUND_CHK_EN
            if (out_of_range) begin
              state   <= ERR;
              err     <= 1'b1;
              io_done <= 1'b1;
            end else
`endif
            begin
              state        <= ACCESS;
              read_enable  <= ~writemode;
              write_enable <= writemode;
              if (writemode) begin
                w_data <= i_w_data;
                w_next <= 1'b1;
              end
            end
          end
        end
        ACCESS: begin
          if (wait_cnt == '0) begin
            read_enable  <= 1'b0;
            write_enable <= 1'b0;
            r_valid      <= ~mode;
            if (!mode) i_r_data <= r_data;
            if (word_cnt != '0) begin
              state    <= GAP;
              address  <= address + 1'b1;
              word_cnt <= word_cnt - 1'b1;
            end else begin
              state   <= DONE;
              io_done <= 1'b1;
            end
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end
        GAP: begin
          state        <= ACCESS;
          wait_cnt     <= WAIT_LOAD;
          read_enable  <= ~mode;
          write_enable <= mode;
          if (mode) begin
            w_data <= i_w_data;
            w_next <= 1'b1;
          end
        end
        DONE, ERR: state <= IDLE;
        default:   state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_burst_ctrl.sv
// Directed bench for sram_burst_ctrl with a behavioural 64K x 32 SRAM model.
// Cycle n of a request is the cycle after its n-th edge; edge 0 samples start.
module tb_sram_burst_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        writemode;
  logic [15:0] i_address;
  logic [4:0]  i_len;
  logic [31:0] i_w_data;
  logic        w_next;
  logic [31:0] i_r_data;
  logic        r_valid;
  logic        busy;
  logic        io_done;
  logic        err;
  logic        read_enable;
  logic        write_enable;
  logic [15:0] address;
  logic [31:0] w_data;
  logic [31:0] r_data;

  always #5 clk = ~clk;

  sram_burst_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .writemode    (writemode),
    .i_address    (i_address),
    .i_len        (i_len),
    .i_w_data     (i_w_data),
    .w_next       (w_next),
    .i_r_data     (i_r_data),
    .r_valid      (r_valid),
    .busy         (busy),
    .io_done      (io_done),
    .err          (err),
    .read_enable  (read_enable),
    .write_enable (write_enable),
    .address      (address),
    .w_data       (w_data),
    .r_data       (r_data)
  );

  logic [31:0] mem [0:65535];

  function automatic logic [31:0] pat(input int a);
    return 32'hC0DE_0000 + 32'(a) * 32'd3;
  endfunction

  always @(posedge clk) if (write_enable) mem[address] <= w_data;
  assign r_data = mem[address];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // per-request observations
  int          done_cyc, n_done, n_wnext, n_err, re_cyc, we_cyc, both_hi, busy_after;
  int          rv_cyc[$];
  logic [31:0] rd_word[$];
  logic [15:0] acc_addr[$];
  logic [1:0]  en_hist [0:255];

  task automatic do_req(input logic wm, input logic [15:0] a, input logic [4:0] l,
                        input logic [31:0] wbase, input int poke_cyc);
    logic en_prev;
    int   wcount;
    done_cyc = 0; n_done = 0; n_wnext = 0; n_err = 0; re_cyc = 0; we_cyc = 0;
    both_hi = 0; busy_after = -1; wcount = 0; en_prev = 1'b0;
    rv_cyc.delete(); rd_word.delete(); acc_addr.delete();
    for (int i = 0; i < 256; i++) en_hist[i] = 2'b00;
    writemode = wm; i_address = a; i_len = l; i_w_data = wbase; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk);
      if (done_cyc != 0 && c == done_cyc + 1) begin
        busy_after = int'(busy);
        break;
      end
      en_hist[c] = {write_enable, read_enable};
      if (read_enable && write_enable) both_hi++;
      if ((read_enable || write_enable) && !en_prev) acc_addr.push_back(address);
      en_prev = read_enable || write_enable;
      if (read_enable)  re_cyc++;
      if (write_enable) we_cyc++;
      if (r_valid) begin rv_cyc.push_back(c); rd_word.push_back(i_r_data); end
      if (w_next) begin n_wnext++; wcount++; i_w_data = wbase + 32'(wcount); end
      if (err) n_err++;
      if (io_done) begin done_cyc = c; n_done++; end
      start = (c == poke_cyc);
    end
    start = 1'b0;
    check_val("request completes within budget", 64'(done_cyc != 0), 64'd1);
  endtask

  task automatic idle_watch(input int n, output int dones, output int busies);
    dones = 0; busies = 0;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      if (io_done) dones++;
      if (busy)    busies++;
    end
  endtask

  int d_cnt, b_cnt;

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = pat(i);
    rst = 1'b1; start = 1'b0; writemode = 1'b0; i_address = '0; i_len = '0; i_w_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("reset busy", 64'(busy), 64'd0);
    check_val("reset enables", 64'({read_enable, write_enable}), 64'd0);
    check_val("reset address", 64'(address), 64'd0);
    check_val("reset pulses", 64'({io_done, r_valid, w_next, err}), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // reset in the middle of a write burst
    writemode = 1'b1; i_address = 16'h0400; i_len = 5'd4; i_w_data = 32'h55; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (6) @(negedge clk);
    check_val("pre-reset write enable", 64'(write_enable), 64'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    check_val("mid-burst reset enables", 64'({read_enable, write_enable}), 64'd0);
    check_val("mid-burst reset busy", 64'(busy), 64'd0);
    check_val("mid-burst reset address", 64'(address), 64'd0);
    check_val("mid-burst reset io_done", 64'(io_done), 64'd0);
    @(posedge clk); #1 rst = 1'b0;
    idle_watch(20, d_cnt, b_cnt);
    check_val("post-reset no io_done", 64'(d_cnt), 64'd0);
    check_val("post-reset stays idle", 64'(b_cnt), 64'd0);

    // single read, length 0 treated as 1
    do_req(1'b0, 16'h0010, 5'd0, 32'h0, 0);
    check_val("single read done cycle", 64'(done_cyc), 64'd4);
    check_val("single read re cycles", 64'(re_cyc), 64'd3);
    check_val("single read re in cycle 1", 64'(en_hist[1]), 64'b01);
    check_val("single read re in cycle 3", 64'(en_hist[3]), 64'b01);
    check_val("single read enables low cycle 4", 64'(en_hist[4]), 64'b00);
    check_val("single read r_valid count", 64'(rv_cyc.size()), 64'd1);
    if (rv_cyc.size() >= 1) begin
      check_val("single read r_valid cycle", 64'(rv_cyc[0]), 64'd4);
      check_val("single read data", 64'(rd_word[0]), 64'(pat(16'h0010)));
    end
    check_val("single read busy after", 64'(busy_after), 64'd0);

    // write burst of 4
    do_req(1'b1, 16'h0100, 5'd4, 32'hA0, 0);
    check_val("write burst done cycle", 64'(done_cyc), 64'd16);
    check_val("write burst w_next pulses", 64'(n_wnext), 64'd4);
    check_val("write burst we cycles", 64'(we_cyc), 64'd12);
    check_val("write burst no read enable", 64'(re_cyc), 64'd0);
    check_val("write burst no r_valid", 64'(rv_cyc.size()), 64'd0);
    for (int k = 0; k < 4; k++)
      check_val($sformatf("write burst mem[%0h]", 16'h0100 + k), 64'(mem[16'h0100 + k]), 64'(32'hA0 + k));
    check_val("write burst neighbour untouched", 64'(mem[16'h0104]), 64'(pat(16'h0104)));

    // read burst of 3
    do_req(1'b0, 16'h0200, 5'd3, 32'h0, 0);
    check_val("read burst done cycle", 64'(done_cyc), 64'd12);
    check_val("read burst r_valid count", 64'(rv_cyc.size()), 64'd3);
    if (rv_cyc.size() == 3) begin
      for (int k = 0; k < 3; k++) begin
        check_val($sformatf("read burst r_valid cycle %0d", k), 64'(rv_cyc[k]), 64'(4 * (k + 1)));
        check_val($sformatf("read burst data %0d", k), 64'(rd_word[k]), 64'(pat(16'h0200 + k)));
      end
    end
    check_val("read burst gap cycle 4", 64'(en_hist[4]), 64'b00);
    check_val("read burst gap cycle 8", 64'(en_hist[8]), 64'b00);
    check_val("read burst re in cycle 5", 64'(en_hist[5]), 64'b01);
    check_val("read burst never both", 64'(both_hi), 64'd0);

    // start pulsed while busy
    do_req(1'b0, 16'h0300, 5'd2, 32'h0, 3);
    check_val("busy start done cycle", 64'(done_cyc), 64'd8);
    check_val("busy start single io_done", 64'(n_done), 64'd1);
    idle_watch(15, d_cnt, b_cnt);
    check_val("busy start no extra request", 64'(b_cnt), 64'd0);
    check_val("busy start no extra io_done", 64'(d_cnt), 64'd0);

    // burst across the top of the address space
    do_req(1'b0, 16'hFFFF, 5'd2, 32'h0, 0);
`ifdef SRAM_BURST_CTRL_BOUND_CHK_EN
    check_val("wrap reject done cycle", 64'(done_cyc), 64'd1);
    check_val("wrap reject err pulses", 64'(n_err), 64'd1);
    check_val("wrap reject no enables", 64'(re_cyc + we_cyc), 64'd0);
    check_val("wrap reject no r_valid", 64'(rv_cyc.size()), 64'd0);
`else
    check_val("wrap done cycle", 64'(done_cyc), 64'd8);
    check_val("wrap no err", 64'(n_err), 64'd0);
    check_val("wrap access count", 64'(acc_addr.size()), 64'd2);
    if (acc_addr.size() == 2) begin
      check_val("wrap first address", 64'(acc_addr[0]), 64'hFFFF);
      check_val("wrap second address", 64'(acc_addr[1]), 64'h0000);
    end
    if (rd_word.size() == 2) begin
      check_val("wrap data 0", 64'(rd_word[0]), 64'(pat(16'hFFFF)));
      check_val("wrap data 1", 64'(rd_word[1]), 64'(pat(0)));
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
